cpu_control_unit: RTL and testbench

Control and program-sequencing block for the single-cycle 8-bit processor. It decodes each 32-bit instruction into the ALU SELECT code, register-file controls and operand-mux selects, and it owns the program counter, including jump and branch-on-equal redirection. It is the driving end of the ALU interface: its ALUOP output feeds the ALU SELECT input, and it consumes the ALU zero flag for branches.

---
 rtl/cpu_control_unit_if.sv | 31 +++
 rtl/cpu_control_unit.sv | 98 +++++++++
 tb/tb_cpu_control_unit.sv | 269 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_control_unit_if.sv
// Control-unit bus: instruction/flag in, PC and decoded controls out.
// master = control unit (drives PC/controls), slave = datapath side.
interface cpu_control_unit_if #(
    parameter int PC_WIDTH = 32
);
    logic [31:0]         INSTRUCTION;
    logic                ZERO;
    logic [PC_WIDTH-1:0] PC;
    logic [2:0]          ALUOP;
    logic                WRITEENABLE;
    logic [2:0]          WRITEREG;
    logic [2:0]          READREG1;
    logic [2:0]          READREG2;
    logic [7:0]          IMMEDIATE;
    logic                IMMSEL;
    logic                NEGSEL;
    logic                BRANCH_TAKEN;
    logic                HALTED;

    modport master (
        input  INSTRUCTION, ZERO,
        output PC, ALUOP, WRITEENABLE, WRITEREG, READREG1, READREG2,
        output IMMEDIATE, IMMSEL, NEGSEL, BRANCH_TAKEN, HALTED
    );

    modport slave (
        output INSTRUCTION, ZERO,
        input  PC, ALUOP, WRITEENABLE, WRITEREG, READREG1, READREG2,
        input  IMMEDIATE, IMMSEL, NEGSEL, BRANCH_TAKEN, HALTED
    );
endinterface

// File: rtl/cpu_control_unit.sv
// Decode and PC sequencing for the single-cycle 8-bit CPU.
// Ports: CLK, RESET (sync, active high), bus (master modport of cpu_control_unit_if).
module cpu_control_unit #(
    parameter int PC_WIDTH = 32,
    parameter int PC_STEP  = 4
) (
    input logic              CLK,
    input logic              RESET,
    cpu_control_unit_if.master bus
);
    typedef enum logic {RUN, HALT} state_t;

    state_t              state, state_nxt;
    logic [PC_WIDTH-1:0] pc, pc_nxt, pc_seq, pc_tgt;
    logic [7:0]          op, off;

    assign op  = bus.INSTRUCTION[31:24];
    assign off = bus.INSTRUCTION[23:16];

    assign pc_seq = pc + PC_WIDTH'(PC_STEP);
    // Offset is signed and counts words.
    assign pc_tgt = pc_seq + {{(PC_WIDTH-10){off[7]}}, off, 2'b00};

    assign bus.PC        = pc;
    assign bus.HALTED    = (state == HALT);
    assign bus.WRITEREG  = bus.INSTRUCTION[18:16];
    assign bus.READREG1  = bus.INSTRUCTION[10:8];
    assign bus.READREG2  = bus.INSTRUCTION[2:0];
    assign bus.IMMEDIATE = bus.INSTRUCTION[7:0];

    always_comb begin
        bus.ALUOP        = 3'b000;
        bus.IMMSEL       = 1'b0;
        bus.NEGSEL       = 1'b0;
        bus.WRITEENABLE  = 1'b0;
        bus.BRANCH_TAKEN = 1'b0;
        pc_nxt           = pc;
        state_nxt        = state;
        if (state == RUN) begin
            pc_nxt = pc_seq;
            unique case (op)
                8'h00: begin
                    bus.IMMSEL      = 1'b1;
                    bus.WRITEENABLE = 1'b1;
                end
                8'h01: bus.WRITEENABLE = 1'b1;
                8'h02: begin
                    bus.ALUOP       = 3'b001;
                    bus.WRITEENABLE = 1'b1;
                end
                8'h03: begin
                    bus.ALUOP       = 3'b001;
                    bus.NEGSEL      = 1'b1;
                    bus.WRITEENABLE = 1'b1;
                end
                8'h04: begin
                    bus.ALUOP       = 3'b010;
                    bus.WRITEENABLE = 1'b1;
                end
                8'h05: begin
                    bus.ALUOP       = 3'b011;
                    bus.WRITEENABLE = 1'b1;
                end
                8'h06: begin
                    bus.BRANCH_TAKEN = 1'b1;
                    pc_nxt           = pc_tgt;
                end
                8'h07: begin
                    bus.ALUOP  = 3'b001;
                    bus.NEGSEL = 1'b1;
                    if (bus.ZERO) begin
                        bus.BRANCH_TAKEN = 1'b1;
                        pc_nxt           = pc_tgt;
                    end
                end
                default: begin
                    pc_nxt    = pc;
                    state_nxt = HALT;
                end
            endcase
        end
        // Reset dominates any decoded write or redirect.
        if (RESET) begin
            bus.WRITEENABLE  = 1'b0;
            bus.BRANCH_TAKEN = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            pc    <= '0;
            state <= RUN;
        end else begin
            pc    <= pc_nxt;
            state <= state_nxt;
        end
    end
endmodule

// File: tb/tb_cpu_control_unit.sv
// Directed self-checking bench for cpu_control_unit.
// Drives vectors after the clock edge and checks comb and PC values.
module tb_cpu_control_unit;
    logic CLK = 1'b0;
    logic RESET = 1'b0;
    int   tests = 0;
    int   fails = 0;

    localparam logic [31:0] ADD = 32'h02000102;

    cpu_control_unit_if #(.PC_WIDTH(32)) bus ();

    cpu_control_unit #(.PC_WIDTH(32), .PC_STEP(4)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.master)
    );

    always #5 CLK = ~CLK;

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic goto_pc(input logic [31:0] target);
        logic [31:0] d;
        RESET = 1'b1;
        bus.ZERO = 1'b0;
        bus.INSTRUCTION = ADD;
        step();
        RESET = 1'b0;
        if (target != 32'h0) begin
            d = (target - 32'd4) >> 2;
            bus.INSTRUCTION = {8'h06, d[7:0], 16'h0000};
            step();
        end
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        bus.ZERO = 1'b0;
        bus.INSTRUCTION = ADD;
        #1;
        tests++;
        if (bus.WRITEENABLE !== 1'b0) begin
            fails++;
            $display("FAIL reset_we got %b exp 0", bus.WRITEENABLE);
        end
        step();
        tests++;
        if (bus.PC !== 32'h0) begin
            fails++;
            $display("FAIL reset_pc got %h exp 0", bus.PC);
        end
        tests++;
        if (bus.HALTED !== 1'b0) begin
            fails++;
            $display("FAIL reset_halted got %b exp 0", bus.HALTED);
        end
        RESET = 1'b0;
    endtask

    task automatic test_step();
        goto_pc(32'h0);
        for (int i = 0; i < 3; i++) begin
            bus.INSTRUCTION = ADD;
            #1;
            tests++;
            if (bus.PC !== 32'(4 * i) || bus.ALUOP !== 3'b001 ||
                bus.WRITEENABLE !== 1'b1) begin
                fails++;
                $display("FAIL step%0d got pc=%h op=%b we=%b exp pc=%h op=001 we=1",
                         i, bus.PC, bus.ALUOP, bus.WRITEENABLE, 4 * i);
            end
            step();
        end
        tests++;
        if (bus.PC !== 32'd12) begin
            fails++;
            $display("FAIL step_pc12 got %h exp c", bus.PC);
        end
    endtask

    task automatic test_decode();
        logic [2:0] e_op [6] = '{3'b000, 3'b000, 3'b001, 3'b001, 3'b010, 3'b011};
        logic       e_im [6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        logic       e_ng [6] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        goto_pc(32'h10);
        tests++;
        if (bus.PC !== 32'h10) begin
            fails++;
            $display("FAIL decode_pc got %h exp 10", bus.PC);
        end
        for (int i = 0; i < 6; i++) begin
            bus.INSTRUCTION = {8'(i), 8'h05, 8'h00, 8'h07};
            #1;
            tests++;
            if (bus.ALUOP !== e_op[i] || bus.IMMSEL !== e_im[i] ||
                bus.NEGSEL !== e_ng[i] || bus.WRITEENABLE !== 1'b1) begin
                fails++;
                $display("FAIL decode_op%0d got %b/%b/%b/%b exp %b/%b/%b/1", i,
                         bus.ALUOP, bus.IMMSEL, bus.NEGSEL, bus.WRITEENABLE,
                         e_op[i], e_im[i], e_ng[i]);
            end
        end
        bus.INSTRUCTION = 32'h00050007;
        #1;
        tests++;
        if (bus.WRITEREG !== 3'd5 || bus.IMMEDIATE !== 8'h07) begin
            fails++;
            $display("FAIL decode_fields got wr=%0d imm=%h exp wr=5 imm=07",
                     bus.WRITEREG, bus.IMMEDIATE);
        end
        bus.INSTRUCTION = 32'h02030406;
        #1;
        tests++;
        if (bus.WRITEREG !== 3'd3 || bus.READREG1 !== 3'd4 ||
            bus.READREG2 !== 3'd6) begin
            fails++;
            $display("FAIL decode_regs got %0d/%0d/%0d exp 3/4/6",
                     bus.WRITEREG, bus.READREG1, bus.READREG2);
        end
    endtask

    task automatic test_jump();
        goto_pc(32'h20);
        bus.INSTRUCTION = 32'h06FE0000;
        #1;
        tests++;
        if (bus.BRANCH_TAKEN !== 1'b1 || bus.WRITEENABLE !== 1'b0) begin
            fails++;
            $display("FAIL jump_ctl got bt=%b we=%b exp bt=1 we=0",
                     bus.BRANCH_TAKEN, bus.WRITEENABLE);
        end
        step();
        tests++;
        if (bus.PC !== 32'h1C) begin
            fails++;
            $display("FAIL jump_back got %h exp 1c", bus.PC);
        end
        goto_pc(32'h20);
        bus.INSTRUCTION = 32'h067F0000;
        step();
        tests++;
        if (bus.PC !== 32'h220) begin
            fails++;
            $display("FAIL jump_fwd got %h exp 220", bus.PC);
        end
    endtask

    task automatic test_beq();
        goto_pc(32'h40);
        bus.INSTRUCTION = 32'h07030000;
        bus.ZERO = 1'b1;
        #1;
        tests++;
        if (bus.BRANCH_TAKEN !== 1'b1 || bus.WRITEENABLE !== 1'b0 ||
            bus.ALUOP !== 3'b001 || bus.NEGSEL !== 1'b1) begin
            fails++;
            $display("FAIL beq_taken_ctl got bt=%b we=%b op=%b ng=%b exp 1/0/001/1",
                     bus.BRANCH_TAKEN, bus.WRITEENABLE, bus.ALUOP, bus.NEGSEL);
        end
        step();
        tests++;
        if (bus.PC !== 32'h50) begin
            fails++;
            $display("FAIL beq_taken_pc got %h exp 50", bus.PC);
        end
        goto_pc(32'h40);
        bus.INSTRUCTION = 32'h07030000;
        bus.ZERO = 1'b0;
        #1;
        tests++;
        if (bus.BRANCH_TAKEN !== 1'b0 || bus.WRITEENABLE !== 1'b0) begin
            fails++;
            $display("FAIL beq_nt_ctl got bt=%b we=%b exp 0/0",
                     bus.BRANCH_TAKEN, bus.WRITEENABLE);
        end
        step();
        tests++;
        if (bus.PC !== 32'h44) begin
            fails++;
            $display("FAIL beq_nt_pc got %h exp 44", bus.PC);
        end
    endtask

    task automatic test_halt();
        goto_pc(32'h08);
        bus.INSTRUCTION = 32'hAA000000;
        #1;
        tests++;
        if (bus.WRITEENABLE !== 1'b0 || bus.ALUOP !== 3'b000 ||
            bus.BRANCH_TAKEN !== 1'b0) begin
            fails++;
            $display("FAIL illegal_ctl got we=%b op=%b bt=%b exp 0/000/0",
                     bus.WRITEENABLE, bus.ALUOP, bus.BRANCH_TAKEN);
        end
        step();
        bus.INSTRUCTION = ADD;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests++;
            if (bus.HALTED !== 1'b1 || bus.PC !== 32'h08 ||
                bus.WRITEENABLE !== 1'b0 || bus.ALUOP !== 3'b000) begin
                fails++;
                $display("FAIL halt%0d got h=%b pc=%h we=%b op=%b exp 1/08/0/000",
                         i, bus.HALTED, bus.PC, bus.WRITEENABLE, bus.ALUOP);
            end
            step();
        end
        RESET = 1'b1;
        step();
        RESET = 1'b0;
        tests++;
        if (bus.PC !== 32'h0 || bus.HALTED !== 1'b0) begin
            fails++;
            $display("FAIL halt_reset got pc=%h h=%b exp 0/0", bus.PC, bus.HALTED);
        end
    endtask

    task automatic test_wrap_override();
        goto_pc(32'hFFFFFFFC);
        tests++;
        if (bus.PC !== 32'hFFFFFFFC) begin
            fails++;
            $display("FAIL wrap_setup got %h exp fffffffc", bus.PC);
        end
        bus.INSTRUCTION = ADD;
        step();
        tests++;
        if (bus.PC !== 32'h0) begin
            fails++;
            $display("FAIL wrap_pc got %h exp 0", bus.PC);
        end
        goto_pc(32'h20);
        bus.INSTRUCTION = 32'h067F0000;
        RESET = 1'b1;
        #1;
        tests++;
        if (bus.WRITEENABLE !== 1'b0 || bus.BRANCH_TAKEN !== 1'b0) begin
            fails++;
            $display("FAIL override_ctl got we=%b bt=%b exp 0/0",
                     bus.WRITEENABLE, bus.BRANCH_TAKEN);
        end
        step();
        RESET = 1'b0;
        tests++;
        if (bus.PC !== 32'h0) begin
            fails++;
            $display("FAIL override_pc got %h exp 0", bus.PC);
        end
    endtask

    initial begin
        bus.INSTRUCTION = ADD;
        bus.ZERO = 1'b0;
        #2;
        test_reset();
        test_step();
        test_decode();
        test_jump();
        test_beq();
        test_halt();
        test_wrap_override();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
